pixel_word_packer: RTL and testbench
====================================

Name: pixel_word_packer

Overview:
- Capture-side stage directly upstream of the capture FIFO: samples camera-style pixel bytes (vsync/href/8-bit data), packs 4 bytes into one 32-bit word, and issues one push strobe per word to the FIFO write side.
- Tracks frame/line boundaries, pads partial words at end of line, and flags words lost while the FIFO is busy.
- Camera signals arrive already synchronised to clock.

Parameters:
- DATA_WIDTH, 32, packed word width; must equal BYTES_PER_WORD*PIXEL_WIDTH.
- PIXEL_WIDTH, 8, width of one incoming byte.
- BYTES_PER_WORD, 4, bytes packed per word.
- LINE_BYTES, 1280, maximum bytes accepted per line; excess bytes are discarded.
- LINE_COUNT_WIDTH, 16, width of line counter.

Ports:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  high = capture allowed; low = abort to IDLE.
- vsync  in  1  frame sync, high between frames.
- href  in  1  high while line bytes are valid.
- pixel_data  in  PIXEL_WIDTH  byte sampled every clock while href=1.
- fifo_busy  in  1  high = FIFO cannot accept a push this cycle.
- word_data  out  DATA_WIDTH  packed word, stable while word_push=1.
- word_push  out  1  single-cycle push strobe to FIFO.
- frame_start  out  1  one-cycle pulse at first line of a frame.
- frame_done  out  1  one-cycle pulse at end of frame.
- overflow  out  1  sticky: a word was dropped because fifo_busy=1.
- line_count  out  LINE_COUNT_WIDTH  lines completed in current frame.

Behaviour:
- Reset (reset_n=0, async): state=IDLE; word_data=0, word_push=0, frame_start=0, frame_done=0, overflow=0, line_count=0; byte index and line byte counter cleared.
- FSM states:
  - IDLE -> WAIT_FRAME when enable=1.
  - WAIT_FRAME: waits for vsync falling edge (registered vsync=1, current vsync=0) -> ACTIVE; pulses frame_start, clears line_count. href is ignored in this state, so a mid-frame enable never captures a partial frame.
  - ACTIVE -> WAIT_FRAME on vsync rising edge; pulses frame_done that same cycle.
  - Any state -> IDLE on enable=0 the next clock; any partial word is discarded, no push, no frame_done.
- Packing:
  - Little-endian: first byte of a word goes to [7:0], fourth to [31:24].
  - Byte index increments per accepted byte and wraps BYTES_PER_WORD-1 -> 0.
- Latency:
  - The clock that samples the 4th byte registers word_data.
  - word_push=1 on the following cycle for exactly one cycle.
  - Back-to-back words give push every 4th cycle.
- End of line (href falling edge in ACTIVE):
  - If byte index != 0, the partial word is zero-padded in the upper bytes and pushed with the same 1-cycle latency.
  - line_count increments, saturating at all-ones.
  - Byte index and line byte counter reset.
- Line overrun: bytes beyond LINE_BYTES in one line are dropped; they cause no push and no error flag.
- FIFO busy:
  - fifo_busy is evaluated in the cycle word_push would assert.
  - If 1: word_push stays 0, the word is dropped, and overflow sets.
  - overflow clears only on reset_n or on the next frame_start.
  - No retry or buffering beyond one word.
- Simultaneous events:
  - href falling with vsync rising: the partial word is pushed and the line counted before frame_done.
  - frame_done is delayed one cycle if needed so it follows the last push.

Decomposition:
- Shared capture package holds the FSM state encoding (IDLE, WAIT_FRAME, ACTIVE) and the default widths DATA_WIDTH/PIXEL_WIDTH, so the FIFO and packer agree.
- One natural sub-module: edge_detector (registered previous value; rise/fall pulses), instantiated for vsync and href.

Test Plan:
- Reset then enable=1; vsync 1->0; href=1 for bytes 0x11,0x22,0x33,0x44 -> one cycle after 0x44 is sampled, word_push=1 with word_data=0x44332211; frame_start pulsed once at vsync fall.
- Line of 6 bytes 0x01..0x06 -> pushes 0x04030201, then after href falls 0x00000605; line_count=1.
- fifo_busy=1 during the push cycle of the second word -> word_push stays 0, overflow=1 and held; next frame's frame_start clears it.
- 3 lines of 8 bytes then vsync rise -> 6 pushes, line_count=3, frame_done single pulse after the last push.
- enable dropped after 2 bytes of a word -> no push, state IDLE; re-enable with href already high mid-frame -> no capture until the next vsync falling edge.
- reset_n asserted mid-line with a partial word -> all outputs 0 immediately (async), no spurious push after release.

Source files
------------

// File: rtl/pixel_word_packer_pkg.sv
// Shared capture definitions: FSM encoding and default widths
// used by both the packer and the capture FIFO.
package pixel_word_packer_pkg;

  localparam int PKR_DATA_WIDTH  = 32;
  localparam int PKR_PIXEL_WIDTH = 8;
  localparam int PKR_BYTES_PER_WORD = 4;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_WAIT_FRAME = 2'd1;
  localparam logic [1:0] ST_ACTIVE     = 2'd2;

  function automatic int pkr_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pixel_word_packer_edge_detector.sv
// Registered previous value of a synchronous level,
// with combinational rise/fall pulses against the current value.
module pixel_word_packer_edge_detector (
  input  logic clock,
  input  logic reset_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic prev;

  // remember last cycle's level
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) prev <= 1'b0;
    else          prev <= din;
  end

  assign rise = din & ~prev;
  assign fall = ~din & prev;

endmodule

// File: rtl/pixel_word_packer.sv
// Camera byte stream to 32-bit word packer with frame/line
// tracking, end-of-line padding and dropped-word flag.
module pixel_word_packer
  import pixel_word_packer_pkg::*;
#(
  parameter int DATA_WIDTH       = PKR_DATA_WIDTH,
  parameter int PIXEL_WIDTH      = PKR_PIXEL_WIDTH,
  parameter int BYTES_PER_WORD   = PKR_BYTES_PER_WORD,
  parameter int LINE_BYTES       = 1280,
  parameter int LINE_COUNT_WIDTH = 16
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic                        vsync,
  input  logic                        href,
  input  logic [PIXEL_WIDTH-1:0]      pixel_data,
  input  logic                        fifo_busy,
  output logic [DATA_WIDTH-1:0]       word_data,
  output logic                        word_push,
  output logic                        frame_start,
  output logic                        frame_done,
  output logic                        overflow,
  output logic [LINE_COUNT_WIDTH-1:0] line_count
);

  localparam int IW = pkr_idx_width(BYTES_PER_WORD);
  localparam int CW = $clog2(LINE_BYTES + 1);

  logic [1:0]            state;
  logic [IW-1:0]         idx;
  logic [CW-1:0]         line_bytes;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] merged;
  logic                  pend;
  logic                  done_pend;
  logic                  in_line;

  logic vs_rise, vs_fall;
  logic hr_rise, hr_fall;

  logic active, take, last, eol, pad, load;

  pixel_word_packer_edge_detector u_vs_edge (
    .clock   (clock),
    .reset_n (reset_n),
    .din     (vsync),
    .rise    (vs_rise),
    .fall    (vs_fall)
  );

  pixel_word_packer_edge_detector u_hr_edge (
    .clock   (clock),
    .reset_n (reset_n),
    .din     (href),
    .rise    (hr_rise),
    .fall    (hr_fall)
  );

  // a line is only captured if its href rise was seen in ACTIVE
  assign active = (state == ST_ACTIVE);
  assign take   = active & href & (in_line | hr_rise)
                & (line_bytes < CW'(LINE_BYTES));
  assign last   = (idx == IW'(BYTES_PER_WORD - 1));
  assign eol    = active & hr_fall;
  assign pad    = eol & (idx != '0);
  assign load   = (take & last) | pad;

  // the push is qualified by the FIFO in the cycle it is offered
  assign word_push = pend & ~fifo_busy;

  // accumulator with the current byte dropped into its lane
  always_comb begin
    merged = acc;
    if (take) merged[idx*PIXEL_WIDTH +: PIXEL_WIDTH] = pixel_data;
  end

  // frame FSM, packing, line counting and status flags
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      idx         <= '0;
      line_bytes  <= '0;
      acc         <= '0;
      pend        <= 1'b0;
      done_pend   <= 1'b0;
      in_line     <= 1'b0;
      word_data   <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
      line_count  <= '0;
    end else if (!enable) begin
      state       <= ST_IDLE;
      idx         <= '0;
      line_bytes  <= '0;
      acc         <= '0;
      pend        <= 1'b0;
      done_pend   <= 1'b0;
      in_line     <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      pend        <= load;
      if (load) word_data <= merged;
      if (pend && fifo_busy) overflow <= 1'b1;
      if (done_pend) begin
        frame_done <= 1'b1;
        done_pend  <= 1'b0;
      end
      unique case (state)
        ST_IDLE: state <= ST_WAIT_FRAME;
        ST_WAIT_FRAME: begin
          if (vs_fall) begin
            state       <= ST_ACTIVE;
            frame_start <= 1'b1;
            line_count  <= '0;
            overflow    <= 1'b0;
            idx         <= '0;
            acc         <= '0;
            line_bytes  <= '0;
            in_line     <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          if (hr_rise) in_line <= 1'b1;
          if (take) begin
            line_bytes <= line_bytes + CW'(1);
            idx        <= last ? '0 : idx + IW'(1);
            acc        <= last ? '0 : merged;
          end
          if (eol) begin
            in_line    <= 1'b0;
            idx        <= '0;
            acc        <= '0;
            line_bytes <= '0;
            if (line_count != '1)
              line_count <= line_count + LINE_COUNT_WIDTH'(1);
          end
          if (vs_rise) begin
            state   <= ST_WAIT_FRAME;
            in_line <= 1'b0;
            // hold frame_done back so it lands after a word loaded now
            if (load) done_pend  <= 1'b1;
            else      frame_done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_word_packer.sv
// Scoreboard bench for pixel_word_packer: expected words and
// push cycles queued at drive time, popped on each push.
module tb_pixel_word_packer;

  localparam int LB = 12;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        vsync = 1'b1;
  logic        href = 1'b0;
  logic [7:0]  pixel_data = '0;
  logic        fifo_busy = 1'b0;
  logic [31:0] word_data;
  logic        word_push;
  logic        frame_start;
  logic        frame_done;
  logic        overflow;
  logic [15:0] line_count;

  typedef struct {
    logic [31:0] word;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   pushes = 0;
  int   fs_n = 0;
  int   fd_n = 0;
  int   last_push_cyc = 0;
  int   fd_cyc = 0;

  pixel_word_packer #(
    .LINE_BYTES (LB)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      (enable),
    .vsync       (vsync),
    .href        (href),
    .pixel_data  (pixel_data),
    .fifo_busy   (fifo_busy),
    .word_data   (word_data),
    .word_push   (word_push),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .overflow    (overflow),
    .line_count  (line_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // monitor: every push must match the head of the scoreboard
  always @(negedge clock) begin
    if (word_push) begin
      exp_t e;
      pushes++;
      last_push_cyc = cyc;
      if (sb.size() == 0) begin
        check("extra_push", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check("word", word_data, e.word);
        check("push_cyc", 32'(cyc), 32'(e.cyc));
      end
    end
    if (frame_start) fs_n++;
    if (frame_done) begin
      fd_n++;
      fd_cyc = cyc;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic new_frame();
    vsync = 1'b1;
    step();
    step();
    vsync = 1'b0;
    step();
    step();
  endtask

  // drop: index of the word to refuse with fifo_busy (-1 = none)
  // vs_end: raise vsync in the same cycle href falls
  task automatic drive_line(int n, logic [7:0] base, int drop, bit vs_end);
    int          ib = 0;
    int          wn = 0;
    bit          dn = 1'b0;
    logic [31:0] acc = '0;
    for (int i = 0; i < n; i++) begin
      href = 1'b1;
      pixel_data = base + 8'(i);
      fifo_busy = dn;
      dn = 1'b0;
      if (i < LB) begin
        acc[ib*8 +: 8] = pixel_data;
        ib++;
        if (ib == 4) begin
          if (wn == drop) dn = 1'b1;
          else sb.push_back('{acc, cyc + 1});
          wn++;
          ib = 0;
          acc = '0;
        end
      end
      step();
    end
    href = 1'b0;
    fifo_busy = dn;
    dn = 1'b0;
    if (vs_end) vsync = 1'b1;
    if (ib != 0) begin
      if (wn == drop) dn = 1'b1;
      else sb.push_back('{acc, cyc + 1});
    end
    step();
    fifo_busy = dn;
    step();
    fifo_busy = 1'b0;
    step();
  endtask

  initial begin
    int p0;
    int f0;
    #12;
    check("rst_word", word_data, 32'h0);
    check("rst_push", 32'(word_push), 32'h0);
    check("rst_fs", 32'(frame_start), 32'h0);
    check("rst_fd", 32'(frame_done), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);
    check("rst_lines", 32'(line_count), 32'h0);
    reset_n = 1'b1;
    step();
    enable = 1'b1;
    step();
    step();

    new_frame();
    check("fs_once", 32'(fs_n), 32'd1);
    drive_line(4, 8'h11, -1, 1'b0);
    check("lines_1", 32'(line_count), 32'd1);
    check("push_4b", 32'(pushes), 32'd1);

    drive_line(6, 8'h01, -1, 1'b0);
    check("lines_2", 32'(line_count), 32'd2);
    check("push_6b", 32'(pushes), 32'd3);

    drive_line(8, 8'h80, 1, 1'b0);
    check("ovf_set", 32'(overflow), 32'd1);
    check("push_drop", 32'(pushes), 32'd4);
    repeat (5) step();
    check("ovf_held", 32'(overflow), 32'd1);

    drive_line(16, 8'hA0, -1, 1'b0);
    check("push_ovr", 32'(pushes), 32'd7);
    check("lines_4", 32'(line_count), 32'd4);

    vsync = 1'b1;
    step();
    step();
    check("fd_1", 32'(fd_n), 32'd1);
    check("ovf_frame_end", 32'(overflow), 32'd1);

    new_frame();
    check("fs_2", 32'(fs_n), 32'd2);
    check("ovf_clr", 32'(overflow), 32'd0);
    check("lines_clr", 32'(line_count), 32'd0);
    p0 = pushes;
    for (int l = 0; l < 3; l++) drive_line(8, 8'(8'h20 + 8'(l*16)), -1, 1'b0);
    vsync = 1'b1;
    step();
    step();
    check("push_3x8", 32'(pushes - p0), 32'd6);
    check("lines_3", 32'(line_count), 32'd3);
    check("fd_2", 32'(fd_n), 32'd2);
    check("fd_after", 32'(fd_cyc > last_push_cyc), 32'd1);

    new_frame();
    drive_line(6, 8'hC0, -1, 1'b1);
    step();
    check("fd_3", 32'(fd_n), 32'd3);
    check("fd_delay", 32'(fd_cyc), 32'(last_push_cyc + 1));
    check("lines_sim", 32'(line_count), 32'd1);

    new_frame();
    p0 = pushes;
    href = 1'b1;
    pixel_data = 8'h91;
    step();
    pixel_data = 8'h92;
    step();
    enable = 1'b0;
    href = 1'b0;
    step();
    step();
    step();
    check("abort_push", 32'(pushes), 32'(p0));
    f0 = fs_n;
    enable = 1'b1;
    href = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pixel_data = 8'(8'h70 + 8'(i));
      step();
    end
    href = 1'b0;
    step();
    step();
    check("reen_push", 32'(pushes), 32'(p0));
    check("reen_fs", 32'(fs_n), 32'(f0));
    new_frame();
    check("reen_fs2", 32'(fs_n), 32'(f0 + 1));
    drive_line(4, 8'h50, -1, 1'b0);
    check("reen_cap", 32'(pushes), 32'(p0 + 1));

    drive_line(8, 8'h60, 0, 1'b0);
    check("pre_rst_ovf", 32'(overflow), 32'd1);
    check("pre_rst_lines", 32'(line_count), 32'd2);
    p0 = pushes;
    href = 1'b1;
    pixel_data = 8'hE1;
    step();
    pixel_data = 8'hE2;
    step();
    pixel_data = 8'hE3;
    @(negedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_word", word_data, 32'h0);
    check("arst_push", 32'(word_push), 32'h0);
    check("arst_ovf", 32'(overflow), 32'h0);
    check("arst_lines", 32'(line_count), 32'h0);
    check("arst_fs", 32'(frame_start), 32'h0);
    check("arst_fd", 32'(frame_done), 32'h0);
    #15;
    href = 1'b0;
    reset_n = 1'b1;
    repeat (6) step();
    check("arst_nopush", 32'(pushes), 32'(p0));
    check("sb_drain", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
